// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and the memory
// responder (slave): MAR/MDR side signals plus completion status.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  read_req;
    logic                  write_req;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] MDRout;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  mem_busy;
    logic                  mem_done;
    logic                  mem_error;

    modport master (
        output read_req, write_req, address, MDRout,
        input  Mdatain, mem_busy, mem_done, mem_error
    );

    modport slave (
        input  read_req, write_req, address, MDRout,
        output Mdatain, mem_busy, mem_done, mem_error
    );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: word-addressed RAM behind the MAR/MDR datapath, accessed
// after a programmable number of wait states, with done/error pulses.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic           clock,
    input  logic           clear,
    mem_responder_if.slave bus
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] mdat_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_wr_q;
    logic                  latch_en;
    logic                  ram_we;
    logic                  rd_en;
    logic                  one_req;
    logic                  both_req;

    // 2-state storage so the array powers up as all zeros in simulation
    bit [DATA_WIDTH-1:0] ram [DEPTH];

    assign one_req  = bus.read_req ^ bus.write_req;
    assign both_req = bus.read_req & bus.write_req;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        latch_en = 1'b0;
        ram_we   = 1'b0;
        rd_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (one_req) begin
                    latch_en = 1'b1;
                    busy_d   = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end else if (both_req) begin
                    error_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                ram_we  = op_wr_q;
                rd_en   = ~op_wr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state and visible outputs; clear aborts any access in flight
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            mdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            if (rd_en) begin
                mdat_q <= ram[addr_q];
            end
        end
    end

    // Request snapshot; later changes on address/MDRout cannot reach the access
    always_ff @(posedge clock) begin
        if (latch_en) begin
            addr_q  <= bus.address;
            data_q  <= bus.MDRout;
            op_wr_q <= bus.write_req;
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[addr_q] <= data_q;
        end
    end

    assign bus.Mdatain   = mdat_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_done  = done_q;
    assign bus.mem_error = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a 2-wait-state instance under directed and
// random traffic, plus a zero-wait instance for back-to-back reads.
module tb_mem_responder;
    localparam int WS_A = 2;
    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic clr_a = 1'b1;
    logic clr_b = 1'b1;

    int checks = 0;
    int failures = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [31:0] model [512];
    logic [31:0] mdat_exp_a = '0;

    mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) ifa ();
    mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) ifb ();

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(WS_A)) dut_a (
        .clock(clk), .clear(clr_a), .bus(ifa.slave));
    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) dut_b (
        .clock(clk), .clear(clr_b), .bus(ifb.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor A: pops the scoreboard on every done/error pulse, tracks held read data
    always @(negedge clk) begin
        exp_t e;
        if (clr_a) begin
            mdat_exp_a = '0;
        end else begin
            if (ifa.mem_done || ifa.mem_error) begin
                checks++;
                if (sb_a.size() == 0) begin
                    failures++;
                    $display("FAIL a_unexpected: done=%b error=%b with empty scoreboard", ifa.mem_done, ifa.mem_error);
                end else begin
                    e = sb_a.pop_front();
                    if (ifa.mem_error != (e.kind == K_ERR) || ifa.mem_done != (e.kind != K_ERR)) begin
                        failures++;
                        $display("FAIL a_kind: done=%b error=%b want kind %0d", ifa.mem_done, ifa.mem_error, e.kind);
                    end else if (e.kind == K_RD) begin
                        if (ifa.Mdatain !== e.data) begin
                            failures++;
                            $display("FAIL a_read: got %h want %h", ifa.Mdatain, e.data);
                        end
                        mdat_exp_a = e.data;
                    end
                end
            end
            check("a_mdatain_hold", ifa.Mdatain, mdat_exp_a);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!clr_b && ifb.mem_done) begin
            checks++;
            if (sb_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected: done with empty scoreboard");
            end else begin
                e = sb_b.pop_front();
                if (e.kind == K_RD && ifb.Mdatain !== e.data) begin
                    failures++;
                    $display("FAIL b_read: got %h want %h", ifb.Mdatain, e.data);
                end
            end
        end
    end

    // tweak: 0 none, 1 change address/MDRout during WAIT, 2 pulse the other request while busy
    task automatic issue_a(input int kind, input logic [8:0] a, input logic [31:0] d, input int tweak);
        int n;
        int busy_n;
        bit seen;
        @(negedge clk);
        ifa.address = a;
        ifa.MDRout = d;
        ifa.read_req = (kind == K_RD);
        ifa.write_req = (kind == K_WR);
        if (kind == K_WR) begin
            model[a] = d;
            sb_a.push_back('{K_WR, 32'h0});
        end else begin
            sb_a.push_back('{K_RD, model[a]});
        end
        seen = 1'b0;
        busy_n = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            ifa.read_req = 1'b0;
            ifa.write_req = 1'b0;
            if (tweak == 1 && n == 1) begin
                ifa.address = a + 9'd1;
                ifa.MDRout = 32'h2222_2222;
            end
            if (tweak == 2 && n == 1) begin
                if (kind == K_RD) ifa.write_req = 1'b1;
                else ifa.read_req = 1'b1;
            end
            if (ifa.mem_busy) busy_n++;
            if (ifa.mem_done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || n != WS_A + 2) begin
            failures++;
            $display("FAIL a_latency: done seen=%b at sample %0d want sample %0d", seen, n, WS_A + 2);
        end
        check("a_busy_cycles", busy_n, WS_A + 1);
    endtask

    task automatic illegal_a(input logic [8:0] a);
        @(negedge clk);
        ifa.address = a;
        ifa.read_req = 1'b1;
        ifa.write_req = 1'b1;
        sb_a.push_back('{K_ERR, 32'h0});
        @(negedge clk);
        ifa.read_req = 1'b0;
        ifa.write_req = 1'b0;
        check("a_error_pulse", ifa.mem_error, 1'b1);
        check("a_error_busy", ifa.mem_busy, 1'b0);
        @(negedge clk);
        check("a_error_clears", ifa.mem_error, 1'b0);
        check("a_error_idle", ifa.mem_busy, 1'b0);
    endtask

    task automatic write_b(input logic [8:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        ifb.address = a;
        ifb.MDRout = d;
        ifb.write_req = 1'b1;
        sb_b.push_back('{K_WR, 32'h0});
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            ifb.write_req = 1'b0;
            if (ifb.mem_done) break;
        end
        check("b_write_latency", n, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        exp_dn [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_dt [6] = '{32'h0, 32'h11, 32'h11, 32'h22, 32'h22, 32'h22};

    initial begin
        for (int i = 0; i < 512; i++) model[i] = '0;
        ifa.read_req = 1'b0; ifa.write_req = 1'b0; ifa.address = '0; ifa.MDRout = '0;
        ifb.read_req = 1'b0; ifb.write_req = 1'b0; ifb.address = '0; ifb.MDRout = '0;
        #23;
        check("rst_mdatain", ifa.Mdatain, 32'h0);
        check("rst_busy", ifa.mem_busy, 1'b0);
        check("rst_done", ifa.mem_done, 1'b0);
        check("rst_error", ifa.mem_error, 1'b0);
        @(negedge clk); #2 clr_a = 1'b0; clr_b = 1'b0;

        // preload, read back, then clear asynchronously while done is high
        issue_a(K_WR, 9'h005, 32'hDEAD_BEEF, 0);
        issue_a(K_RD, 9'h005, 32'h0, 0);
        #2 clr_a = 1'b1;
        #1;
        check("async_clr_mdatain", ifa.Mdatain, 32'h0);
        check("async_clr_busy", ifa.mem_busy, 1'b0);
        check("async_clr_done", ifa.mem_done, 1'b0);
        @(negedge clk); #2 clr_a = 1'b0;
        issue_a(K_RD, 9'h005, 32'h0, 0);

        issue_a(K_WR, 9'h012, 32'hA5A5_0001, 0);
        issue_a(K_RD, 9'h012, 32'h0, 0);

        issue_a(K_WR, 9'h020, 32'h1111_1111, 1);
        issue_a(K_RD, 9'h020, 32'h0, 0);
        issue_a(K_RD, 9'h021, 32'h0, 0);

        issue_a(K_RD, 9'h012, 32'h0, 2);
        illegal_a(9'h012);
        issue_a(K_RD, 9'h012, 32'h0, 0);

        // abort a write during WAIT
        issue_a(K_WR, 9'h040, 32'h1234_5678, 0);
        @(negedge clk);
        ifa.address = 9'h040; ifa.MDRout = 32'h3333_3333; ifa.write_req = 1'b1;
        @(negedge clk);
        ifa.write_req = 1'b0;
        #2 clr_a = 1'b1;
        @(negedge clk); #2 clr_a = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", ifa.mem_done, 1'b0);
        end
        check("abort_sb_empty", sb_a.size(), 0);
        issue_a(K_RD, 9'h040, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            logic [8:0] a;
            r = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
            if (r == 0) illegal_a(a);
            else issue_a((r < 5) ? K_WR : K_RD, a, $urandom, int'($urandom_range(0, 1)) * 2);
        end

        // zero-wait instance: read_req held high across two addresses
        write_b(9'h001, 32'h11);
        write_b(9'h002, 32'h22);
        @(negedge clk);
        ifb.address = 9'h001;
        ifb.read_req = 1'b1;
        sb_b.push_back('{K_RD, 32'h11});
        sb_b.push_back('{K_RD, 32'h22});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("b2b_done", ifb.mem_done, exp_dn[i]);
            check("b2b_mdatain", ifb.Mdatain, exp_dt[i]);
            if (i == 0) ifb.address = 9'h002;
            if (i == 3) ifb.read_req = 1'b0;
        end

        repeat (4) @(negedge clk);
        check("end_sb_a_empty", sb_a.size(), 0);
        check("end_sb_b_empty", sb_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
